// File: rtl/parity_step_scheduler.sv
// Round-robin sequencer that shares one step-2 parity counter between two requesters:
// it grants, validates parity, loads the counter, watches it step and freezes it at the target.
module parity_step_scheduler #(
  parameter int WIDTH     = 4,
  parameter int MAX_STEPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] start_0,
  input  logic [WIDTH-1:0] target_0,
  input  logic             mode_0,
  input  logic [WIDTH-1:0] start_1,
  input  logic [WIDTH-1:0] target_1,
  input  logic             mode_1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ctr_load,
  output logic             ctr_mode,
  output logic [WIDTH-1:0] ctr_data,
  input  logic [WIDTH-1:0] ctr_count
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state, state_nx;
  logic               rr_ptr;
  logic               owner;
  logic [WIDTH-1:0]   lat_start;
  logic [WIDTH-1:0]   lat_target;
  logic               lat_mode;
  logic [STEP_W-1:0]  step_cnt;

  logic               win_idx;
  logic [WIDTH-1:0]   win_start;
  logic [WIDTH-1:0]   win_target;
  logic               win_mode;
  logic               parity_ok;
  logic               match;
  logic [STEP_W-1:0]  step_inc;
  logic               timeout;

  // Contention goes to the rr pointer; a lone requester wins outright.
  assign win_idx    = (req == 2'b11) ? rr_ptr : req[1];
  assign win_start  = win_idx ? start_1  : start_0;
  assign win_target = win_idx ? target_1 : target_0;
  assign win_mode   = win_idx ? mode_1   : mode_0;
  assign parity_ok  = (win_start[0] == win_mode) && (win_target[0] == win_mode);

  assign match    = (ctr_count == lat_target);
  assign step_inc = step_cnt + 1'b1;
  assign timeout  = (step_inc == STEP_W'(MAX_STEPS));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it
    // unassigned; a missing default here infers a latch.
    state_nx = state;
    ctr_load = 1'b0;
    ctr_mode = 1'b1;
    ctr_data = '0;
    unique case (state)
      S_IDLE: begin
        if (|req) state_nx = parity_ok ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
        ctr_load = 1'b1;
        ctr_mode = lat_mode;
        ctr_data = lat_start;
        state_nx = S_RUN;
      end
      S_RUN: begin
        // On the match cycle the freeze encoding keeps the counter parked at the target.
        if (match) begin
          state_nx = S_DONE;
        end else begin
          ctr_mode = lat_mode;
          ctr_data = lat_start;
          if (timeout) state_nx = S_ERR;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: all state below updates with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      lat_start  <= '0;
      lat_target <= '0;
      lat_mode   <= 1'b0;
      step_cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            owner      <= win_idx;
            lat_start  <= win_start;
            lat_target <= win_target;
            lat_mode   <= win_mode;
          end
        end
        S_LOAD: step_cnt <= '0;
        S_RUN: begin
          if (!match) step_cnt <= step_inc;
        end
        S_DONE:  rr_ptr <= ~owner;
        S_ERR:   rr_ptr <= ~owner;
        default: ;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign done  = (state == S_DONE);
  assign err   = (state == S_ERR);

endmodule

// File: tb/tb_parity_step_scheduler.sv
// Self-checking bench for parity_step_scheduler with a behavioural step-2 counter model,
// a table of single-run vectors and hand sequences for reset and round-robin.
module tb_parity_step_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] start_0, target_0, start_1, target_1;
  logic       mode_0, mode_1;
  logic [1:0] grant;
  logic       busy, done, err;
  logic       ctr_load, ctr_mode;
  logic [3:0] ctr_data;
  logic [3:0] ctr_count = 4'd0;
  bit         stuck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  parity_step_scheduler #(.WIDTH(4), .MAX_STEPS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .start_0  (start_0),
    .target_0 (target_0),
    .mode_0   (mode_0),
    .start_1  (start_1),
    .target_1 (target_1),
    .mode_1   (mode_1),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ctr_load (ctr_load),
    .ctr_mode (ctr_mode),
    .ctr_data (ctr_data),
    .ctr_count(ctr_count)
  );

  always #5 clk = ~clk;

  // Behavioural counter: load, else +2 when data parity matches mode, else hold.
  always @(posedge clk) begin
    if (ctr_load)                             ctr_count <= ctr_data;
    else if (!stuck && ctr_data[0] == ctr_mode) ctr_count <= ctr_count + 4'd2;
  end

  typedef struct {
    logic [1:0] req;
    logic [3:0] s0, t0;
    logic       m0;
    logic [3:0] s1, t1;
    logic       m1;
    bit         stuck;
    bit         exp_done;
    logic [1:0] exp_grant;
    int         exp_lat;
    bit         chk_cnt;
    logic [3:0] exp_cnt;
    bit         exp_load;
  } vec_t;

  typedef struct {
    bit         done;
    logic [1:0] grant;
    int         lat;
    bit         chk_cnt;
    logic [3:0] cnt;
    bit         load;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] rr_sb[$];
  vec_t       vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    bit   seen_load;
    bit   fin;
    @(negedge clk);
    start_0 = v.s0; target_0 = v.t0; mode_0 = v.m0;
    start_1 = v.s1; target_1 = v.t1; mode_1 = v.m1;
    stuck = v.stuck;
    req = v.req;
    sb.push_back('{v.exp_done, v.exp_grant, v.exp_lat, v.chk_cnt, v.exp_cnt, v.exp_load});
    n = 0; seen_load = 1'b0; fin = 1'b0;
    while (!fin && n < 40) begin
      @(negedge clk);
      n++;
      if (ctr_load) seen_load = 1'b1;
      check("grant_not_both", grant == 2'b11, 0);
      if (done || err) fin = 1'b1;
    end
    e = sb.pop_front();
    check("completion", fin, 1);
    check("done_pulse", done, e.done);
    check("err_pulse", err, !e.done);
    check("grant_at_end", grant, e.grant);
    check("latency", n, e.lat);
    check("load_seen", seen_load, e.load);
    if (e.chk_cnt) check("count_at_end", ctr_count, e.cnt);
    req = 2'b00;
    @(negedge clk);
    check("busy_after", busy, 0);
    check("grant_after", grant, 0);
    check("pulse_after", done | err, 0);
    if (e.chk_cnt) check("count_hold", ctr_count, e.cnt);
    stuck = 1'b0;
  endtask

  initial begin
    int  n;
    bit  fin;

    // req, s0,t0,m0, s1,t1,m1, stuck, done, grant, latency, chk_cnt, cnt, load
    vecs[0] = '{2'b01, 4'd2,  4'd8,  1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 2'b01, 6,  1'b1, 4'd8,  1'b1};
    vecs[1] = '{2'b10, 4'd0,  4'd0,  1'b0, 4'd3, 4'd4,  1'b1, 1'b0, 1'b0, 2'b10, 1,  1'b0, 4'd0,  1'b0};
    vecs[2] = '{2'b01, 4'd13, 4'd1,  1'b1, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 2'b01, 5,  1'b1, 4'd1,  1'b1};
    vecs[3] = '{2'b01, 4'd2,  4'd6,  1'b0, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 2'b01, 10, 1'b1, 4'd2,  1'b1};
    vecs[4] = '{2'b01, 4'd5,  4'd5,  1'b1, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 2'b01, 3,  1'b1, 4'd5,  1'b1};
    vecs[5] = '{2'b10, 4'd0,  4'd0,  1'b0, 4'd0, 4'd14, 1'b0, 1'b0, 1'b1, 2'b10, 10, 1'b1, 4'd14, 1'b1};
    vecs[6] = '{2'b01, 4'd4,  4'd7,  1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b01, 1,  1'b0, 4'd0,  1'b0};

    rst = 1'b1; req = 2'b00;
    start_0 = 4'd0; target_0 = 4'd0; mode_0 = 1'b0;
    start_1 = 4'd0; target_1 = 4'd0; mode_1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ctr_load", ctr_load, 0);
    check("rst_ctr_mode", ctr_mode, 1);
    check("rst_ctr_data", ctr_data, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in RUN at count 6: next cycle idle and frozen, counter not reloaded.
    @(negedge clk);
    start_0 = 4'd2; target_0 = 4'd14; mode_0 = 1'b0;
    req = 2'b01;
    n = 0; fin = 1'b0;
    while (!fin && n < 20) begin
      @(negedge clk);
      n++;
      if (busy && !ctr_load && ctr_count == 4'd6) fin = 1'b1;
    end
    check("reach_count6", fin, 1);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_pulses", done | err, 0);
    check("mid_rst_ctr_load", ctr_load, 0);
    check("mid_rst_ctr_mode", ctr_mode, 1);
    check("mid_rst_ctr_data", ctr_data, 0);
    check("mid_rst_count", ctr_count, 8);
    @(negedge clk);
    check("mid_rst_count_hold", ctr_count, 8);
    rst = 1'b0;

    // Both requesting continuously after reset: requester 0 first, then alternate.
    start_0 = 4'd0; target_0 = 4'd4; mode_0 = 1'b0;
    start_1 = 4'd2; target_1 = 4'd6; mode_1 = 1'b0;
    rr_sb.push_back(2'b01);
    rr_sb.push_back(2'b10);
    rr_sb.push_back(2'b01);
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] eg;
      n = 0; fin = 1'b0;
      while (!fin && n < 20) begin
        @(negedge clk);
        n++;
        check("rr_grant_not_both", grant == 2'b11, 0);
        if (done) fin = 1'b1;
      end
      eg = rr_sb.pop_front();
      check("rr_completion", fin, 1);
      check("rr_grant", grant, eg);
      check("rr_latency", n, (k == 0) ? 5 : 6);
    end
    req = 2'b00;
    @(negedge clk);
    check("rr_idle_after", busy, 0);
    check("rr_final_count", ctr_count, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
